// File: rtl/sseg4_scan.sv
// -----------------------------------------------------------------------------
// sseg4_scan
//
// Time-multiplexed driver for a 4-digit common-anode seven-segment display.
// A load strobe captures a 16-bit hex value, per-digit decimal points and
// per-digit enables into shadow registers. A refresh counter steps through
// the four digits, blanking every digit for the first BLANK_CYCLES cycles of
// its slot to avoid ghosting. All pins are active-low and registered.
//
// Parameters:
//   REFRESH_DIV  : clk cycles per digit slot (2 .. 2**20)
//   BLANK_CYCLES : cycles at the start of each slot with all anodes off
//                  (must be < REFRESH_DIV)
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   load       in   capture strobe for value/dp_in/en_in
//   value      in   [15:0] four hex nibbles, nibble i -> digit i (0 = rightmost)
//   dp_in      in   [3:0] decimal point per digit, 1 = lit
//   en_in      in   [3:0] digit enable per digit, 1 = may be displayed
//   lzb        in   leading-zero blanking enable (live, not shadowed)
//   seg        out  [6:0] segments {g,f,e,d,c,b,a}, active-low
//   dp         out  decimal point, active-low
//   an         out  [3:0] anodes, active-low, at most one bit low
//   frame_tick out  one-cycle pulse when the digit index wraps 3 -> 0
// -----------------------------------------------------------------------------
module sseg4_scan #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  en_in,
  input  logic        lzb,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        frame_tick
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX   = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

  // Active-low segment pattern {g,f,e,d,c,b,a} for one hex nibble.
  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // State
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   val_q, val_d;
  logic [3:0]    dp_sh_q, dp_sh_d;
  logic [3:0]    en_sh_q, en_sh_d;

  // Registered outputs
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic [3:0]    an_q, an_d;
  logic          ft_q, ft_d;

  // Helpers
  logic          wrap;
  logic [3:0]    nib;
  logic [3:0]    dark;   // nibble is zero or digit disabled
  logic [3:0]    sup;    // suppressed by leading-zero blanking
  logic          visible;

  always_comb begin
    wrap = (cnt_q == CNT_MAX);
    nib  = val_q[{idx_q, 2'b00} +: 4];

    for (int i = 0; i < 4; i++) begin
      dark[i] = (val_q[4*i +: 4] == 4'h0) || !en_sh_q[i];
    end

    // Suppression propagates downward from digit 3; digit 0 always shows.
    sup    = 4'b0000;
    sup[3] = lzb && dark[3];
    sup[2] = sup[3] && dark[2];
    sup[1] = sup[2] && dark[1];

    visible = (cnt_q >= BLANK_END) && en_sh_q[idx_q] && !sup[idx_q];

    cnt_d = wrap ? '0 : cnt_q + 1'b1;
    idx_d = wrap ? idx_q + 2'd1 : idx_q;

    val_d   = load ? value : val_q;
    dp_sh_d = load ? dp_in : dp_sh_q;
    en_sh_d = load ? en_in : en_sh_q;

    if (visible) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = decode(nib);
      dp_d  = ~dp_sh_q[idx_q];
    end else begin
      an_d  = 4'b1111;
      seg_d = 7'b1111111;
      dp_d  = 1'b1;
    end

    // High during the cycle in which idx_q has just returned to 0.
    ft_d = wrap && (idx_q == 2'd3);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      val_q   <= 16'h0000;
      dp_sh_q <= 4'b0000;
      en_sh_q <= 4'b0000;
      seg_q   <= 7'b1111111;
      dp_q    <= 1'b1;
      an_q    <= 4'b1111;
      ft_q    <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      val_q   <= val_d;
      dp_sh_q <= dp_sh_d;
      en_sh_q <= en_sh_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      an_q    <= an_d;
      ft_q    <= ft_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_tick = ft_q;

endmodule

// File: tb/tb_sseg4_scan.sv
// -----------------------------------------------------------------------------
// tb_sseg4_scan
//
// Directed bench for sseg4_scan with REFRESH_DIV=4, BLANK_CYCLES=1, so each
// digit slot is 1 blank cycle + 3 lit cycles and a frame is 16 cycles.
// Outputs are sampled on the falling clock edge; inputs change there too.
// The observed word is {an, seg, dp, frame_tick}.
// -----------------------------------------------------------------------------
module tb_sseg4_scan;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [3:0]  en_in;
  logic        lzb;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_tick;

  int checks = 0;
  int errors = 0;

  localparam logic [6:0] S_0   = 7'b1000000;
  localparam logic [6:0] S_1   = 7'b1111001;
  localparam logic [6:0] S_2   = 7'b0100100;
  localparam logic [6:0] S_3   = 7'b0110000;
  localparam logic [6:0] S_A   = 7'b0001000;
  localparam logic [6:0] S_F   = 7'b0001110;
  localparam logic [12:0] OFF  = {4'b1111, 7'b1111111, 1'b1, 1'b0};

  sseg4_scan #(
    .REFRESH_DIV (4),
    .BLANK_CYCLES(1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .value     (value),
    .dp_in     (dp_in),
    .en_in     (en_in),
    .lzb       (lzb),
    .seg       (seg),
    .dp        (dp),
    .an        (an),
    .frame_tick(frame_tick)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [12:0] obs();
    return {an, seg, dp, frame_tick};
  endfunction

  task automatic chk(input string tag, input logic [12:0] got, input logic [12:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed an=%b seg=%b dp=%b ft=%b expected an=%b seg=%b dp=%b ft=%b",
             tag, got[12:9], got[8:2], got[1], got[0], exp[12:9], exp[8:2], exp[1], exp[0]);
    end
  endtask

  // Runs one 16-cycle frame starting from counter 0 / digit 0 and checks
  // every cycle: slot position 0 is blank, positions 1..3 show the digit
  // when it is lit. frame_tick is expected on the last cycle only.
  task automatic check_frame(input string tag, input logic [3:0] lit,
                             input logic [6:0] s3, input logic [6:0] s2,
                             input logic [6:0] s1, input logic [6:0] s0,
                             input logic [3:0] dpm);
    int d, pos;
    logic [3:0] a_e;
    logic [6:0] s_e;
    logic ft_e;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      load = 1'b0;
      d = i / 4;
      pos = i % 4;
      ft_e = (i == 15);
      case (d)
        0: s_e = s0;
        1: s_e = s1;
        2: s_e = s2;
        default: s_e = s3;
      endcase
      a_e = ~(4'b0001 << d);
      if (pos != 0 && lit[d])
        chk($sformatf("%s_c%0d", tag, i), obs(), {a_e, s_e, ~dpm[d], ft_e});
      else
        chk($sformatf("%s_c%0d", tag, i), obs(), {OFF[12:1], ft_e});
    end
  endtask

  initial begin
    rst_n = 1'b0;
    load  = 1'b0;
    value = 16'h0000;
    dp_in = 4'b0000;
    en_in = 4'b0000;
    lzb   = 1'b0;

    // 1. Reset held
    repeat (3) @(negedge clk);
    chk("reset_hold", obs(), OFF);

    // 1+2. Release with a load of 12AF; first lit cycle is digit 0 after one blank
    rst_n = 1'b1;
    load  = 1'b1;
    value = 16'h12AF;
    dp_in = 4'b0100;
    en_in = 4'b1111;
    check_frame("scan12AF_f0", 4'b1111, S_1, S_2, S_A, S_F, 4'b0100);
    // 3. Timing repeats: next frame identical, tick again after 16 cycles
    check_frame("scan12AF_f1", 4'b1111, S_1, S_2, S_A, S_F, 4'b0100);

    // 4. Leading-zero blanking on 0030
    load  = 1'b1;
    value = 16'h0030;
    dp_in = 4'b0000;
    lzb   = 1'b1;
    check_frame("lzb_on", 4'b0011, S_0, S_0, S_3, S_0, 4'b0000);
    lzb = 1'b0;
    check_frame("lzb_off", 4'b1111, S_0, S_0, S_3, S_0, 4'b0000);

    // 5. Load coinciding with the digit 1 -> 2 wrap
    load  = 1'b1;
    value = 16'h1111;
    check_frame("pre1111", 4'b1111, S_1, S_1, S_1, S_1, 4'b0000);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      case (i)
        5:  chk("wrap_d1_old", obs(), {4'b1101, S_1, 1'b1, 1'b0});
        6:  begin
              load  = 1'b1;
              value = 16'h2222;
            end
        7:  begin
              chk("wrap_d1_last", obs(), {4'b1101, S_1, 1'b1, 1'b0});
              load = 1'b0;
            end
        8:  chk("wrap_d2_blank", obs(), OFF);
        9:  chk("wrap_d2_new", obs(), {4'b1011, S_2, 1'b1, 1'b0});
        13: chk("wrap_d3_new", obs(), {4'b0111, S_2, 1'b1, 1'b0});
        15: chk("wrap_tick", obs(), {4'b0111, S_2, 1'b1, 1'b1});
        default: ;
      endcase
    end

    // 6. Asynchronous reset in the middle of digit 2's slot
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 9) chk("pre_areset_d2", obs(), {4'b1011, S_2, 1'b1, 1'b0});
    end
    #2 rst_n = 1'b0;
    #1 chk("areset_immediate", obs(), OFF);
    @(negedge clk);
    chk("areset_held", obs(), OFF);
    rst_n = 1'b1;
    // Shadow registers cleared: nothing lit, tick still at cycle 16
    check_frame("post_reset_empty", 4'b0000, S_0, S_0, S_0, S_0, 4'b0000);
    load  = 1'b1;
    value = 16'h12AF;
    dp_in = 4'b0100;
    en_in = 4'b1111;
    check_frame("post_reset_reload", 4'b1111, S_1, S_2, S_A, S_F, 4'b0100);

    // 5b. Disable digit 2
    load  = 1'b1;
    value = 16'h2222;
    dp_in = 4'b0000;
    en_in = 4'b1011;
    check_frame("en2_off", 4'b1011, S_2, S_2, S_2, S_2, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
